// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, round keys expanded on the fly.
// Latency: accept edge E0, out_valid after edge E(10/UNROLL); back-to-back blocks with no bubble.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready + plaintext/key (128b, byte 0 = MSB);
//        out_valid/out_ready + ciphertext (128b); busy = FSM not IDLE.
module aes128_iter_core #(
  parameter int UNROLL  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
      $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end
  endgenerate

  localparam logic [3:0] STEP     = 4'(UNROLL);
  // r_rnd value at which the final group of rounds ends on round 10
  localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);

  // Forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};  // (255 - b) * 8
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0]  ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  // Byte i (column c = i/4, row r = i%4) lives at bits [127-8i -: 8]
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(st[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(15-(4*c+r)) +: 8] = sb[8*(15-(4*((c+r)%4)+r)) +: 8];
    for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    return (last ? sr : mc) ^ rk;
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_rk;
  logic [3:0]   r_rnd;
  logic [127:0] w_st_nxt, w_rk_nxt;
  logic         w_accept, w_last;

  // Unrolled round chain: rounds r_rnd .. r_rnd+UNROLL-1 in one cycle
  always_comb begin : c_rounds
    logic [127:0] st, rk;
    logic [3:0]   r;
    st = r_state;
    rk = r_rk;
    r  = r_rnd;
    for (int u = 0; u < UNROLL; u++) begin
      r  = r_rnd + 4'(u);
      rk = key_expand(rk, rcon(r));
      st = aes_round(st, rk, r == 4'd10);
    end
    w_st_nxt = st;
    w_rk_nxt = rk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_accept  = 1'b0;
    w_last    = (r_rnd == LAST_RND);
    case (r_fsm)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept  = 1'b1;
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: if (w_last) w_fsm_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Output handshake and next accept share the edge: no idle bubble
        if (out_ready) w_fsm_nxt = in_valid ? ROUND : IDLE;
        w_accept = out_ready & in_valid;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
    end else if (w_accept) begin
      r_state <= plaintext ^ key;
      r_rk    <= key;
      r_rnd   <= 4'd1;
    end else if (r_fsm == ROUND) begin
      r_state <= w_st_nxt;
      r_rk    <= w_rk_nxt;
      r_rnd   <= r_rnd + STEP;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [127:0] r_ct;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_ct <= '0;
        else if (r_fsm == ROUND && w_last)  r_ct <= w_st_nxt;
      end
      assign ciphertext = r_ct;
    end else begin : g_out_state
      assign ciphertext = r_state;
    end
  endgenerate

endmodule

// File: tb/tb_aes128_iter_core.sv
// Testbench for aes128_iter_core: four instances (UNROLL 1/2/5/10, alternating OUT_REG)
// against a FIPS-197 reference model with an algebraically derived S-box.
module tb_aes128_iter_core;

  localparam int NI = 4;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] plaintext, key;
  logic         iv [NI];
  logic         ir [NI];
  logic         ov [NI];
  logic         ordy [NI];
  logic         busy [NI];
  logic [127:0] ct [NI];
  logic         kat_en [NI];
  logic [127:0] kat_ct [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] C2 = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(string nm, int inst, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0b expected=%0b t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic chk128(string nm, int inst, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic chkint(string nm, int inst, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d expected=%0d", nm, inst, act, exp);
    end
  endtask

  task automatic timeout(string nm, int inst);
    checks++;
    failures++;
    $display("FAIL timeout %s inst=%0d actual=no-event required=event", nm, inst);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box = affine(multiplicative inverse in GF(2^8))
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(logic [127:0] pt, logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) t[4*c+j] = sb[s[4*((c+j)%4)+j]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- DUTs, scoreboards and monitors ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int U   = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    localparam int LAT = 10 / U;

    aes128_iter_core #(.UNROLL(U), .OUT_REG((g % 2 == 0) ? 1'b1 : 1'b0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .plaintext (plaintext),
      .key       (key),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .ciphertext(ct[g]),
      .busy      (busy[g])
    );

    exp_t q [$];

    always @(negedge clk) begin : mon
      logic eov;
      exp_t e;
      if (rst_n) begin
        eov = 1'b0;
        if (q.size() > 0) eov = (cyc - q[0].acc) >= LAT;
        chk1("out_valid", g, ov[g], eov);
        chk1("busy", g, busy[g], q.size() > 0);
        chk1("in_ready", g, ir[g], (q.size() == 0) || (eov && ordy[g]));
        if (eov && ov[g]) chk128("ciphertext", g, ct[g], q[0].ct);
        if (eov && ordy[g]) void'(q.pop_front());
        if (iv[g] && ir[g]) begin
          e.ct  = kat_en[g] ? kat_ct[g] : aes_ref(plaintext, key);
          e.acc = cyc + 1;
          q.push_back(e);
        end
      end
    end

    always @(negedge rst_n) q.delete();
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 10 : (k == 1) ? 5 : (k == 2) ? 2 : 1;
  endfunction

  // Offer one block; returns #1 after the accept edge with acc = that edge's cycle number
  task automatic offer(int k, logic [127:0] p, logic [127:0] kk, logic [127:0] exp,
                       bit use_kat, output int acc);
    bit got;
    plaintext = p;
    key       = kk;
    kat_en[k] = use_kat;
    kat_ct[k] = exp;
    iv[k]     = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = ir[k];
      @(posedge clk);
      #1;
    end
    acc = cyc;
    iv[k]     = 1'b0;
    kat_en[k] = 1'b0;
    if (!got) timeout("accept", k);
  endtask

  task automatic wait_idle(int k);
    bit done;
    ordy[k] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = !busy[k] && !ov[k];
    end
    @(posedge clk);
    #1;
    if (!done) timeout("idle", k);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog actual=still-running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1, a2;
    logic [127:0] rp, rk;
    build_sbox();
    rst_n = 1'b0;
    plaintext = '0;
    key = '0;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; kat_en[k] = 1'b0; kat_ct[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("rst_out_valid", k, ov[k], 1'b0);
      chk1("rst_busy", k, busy[k], 1'b0);
      chk128("rst_ciphertext", k, ct[k], '0);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) chk1("rst_in_ready", k, ir[k], 1'b1);
    @(posedge clk);
    #1;

    // Known-answer vectors
    offer(0, P1, K1, C1, 1'b1, a1);
    wait_idle(0);
    for (int k = 0; k < NI; k++) begin
      offer(k, P2, K2, C2, 1'b1, a1);
      wait_idle(k);
    end

    // Backpressure: result held 7 cycles while a second block waits
    for (int k = 0; k < NI; k++) begin
      ordy[k] = 1'b0;
      offer(k, P3, K3, C3, 1'b1, a1);
      for (int n = 0; n < 50 && !ov[k]; n++) begin
        @(posedge clk);
        #1;
      end
      if (!ov[k]) timeout("bp_valid", k);
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      plaintext = rp;
      key = rk;
      iv[k] = 1'b1;
      repeat (7) begin
        @(posedge clk);
        #1;
        chk1("bp_in_ready_low", k, ir[k], 1'b0);
        chk128("bp_ct_hold", k, ct[k], C3);
      end
      ordy[k] = 1'b1;
      offer(k, rp, rk, '0, 1'b0, a2);
      chkint("bp_release_cycle", k, a2, a1 + lat_of(k) + 8);
      wait_idle(k);
    end

    // Back-to-back: second accept on the first output handshake edge
    for (int k = 0; k < NI; k++) begin
      offer(k, '0, '0, CZ, 1'b1, a1);
      offer(k, P3, K3, C3, 1'b1, a2);
      chkint("b2b_gap", k, a2 - a1, lat_of(k) + 1);
      wait_idle(k);
    end

    // Inputs scrambled while rounds are in flight
    for (int k = 0; k < 2; k++) begin
      offer(k, P1, K1, C1, 1'b1, a1);
      repeat (3) begin
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
      end
      wait_idle(k);
    end

    // Reset with instance 0 mid-ROUND (round counter at 6)
    offer(0, P2, K2, C2, 1'b1, a1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("mid_rst_out_valid", k, ov[k], 1'b0);
      chk1("mid_rst_busy", k, busy[k], 1'b0);
      chk128("mid_rst_ciphertext", k, ct[k], '0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) chk1("mid_rst_in_ready", k, ir[k], 1'b1);
    repeat (15) @(posedge clk);
    #1;
    offer(0, P3, K3, C3, 1'b1, a1);
    wait_idle(0);

    // Random traffic: data changes every cycle, random valid and backpressure
    for (int n = 0; n < 3000; n++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < NI; k++) begin
        iv[k]   = ($urandom_range(0, 2) == 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) chk1("drained_busy", k, busy[k], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
